// File: rtl/alu_exec_stage.sv
// Purpose: MIPS execute stage, ALU result and flags delivered through a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid when the stage is empty or draining.
// Backpressure: in_ready drops only when both entries are held; it never depends combinationally on out_ready.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             alu_zero;
  logic             alu_ovf;
  logic             alu_ill;
  logic             slt_bit;

  logic [WIDTH-1:0] main_res,  skid_res;
  logic             main_zero, skid_zero;
  logic             main_ovf,  skid_ovf;
  logic             main_ill,  skid_ill;

  logic accept;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Both entries occupied is the only condition that refuses new work.
  assign in_ready  = (state != S_FULL);
  assign out_valid = (state != S_EMPTY);
  assign accept    = in_valid && in_ready;

  assign result     = main_res;
  assign zero       = main_zero;
  assign overflow   = main_ovf;
  assign illegal_op = main_ill;

  // ALU datapath: result and flags for the operation presented this cycle.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    sum     = operand_a + operand_b;
    diff    = operand_a - operand_b;
    // Direct signed compare stays correct when a-b would overflow.
    slt_bit = ($signed(operand_a) < $signed(operand_b));
    case (alu_ctrl)
      4'b0000: alu_res = operand_a & operand_b;
      4'b0001: alu_res = operand_a | operand_b;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                  (diff[WIDTH-1] != operand_a[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      4'b1100: alu_res = ~(operand_a | operand_b);
      default: alu_ill = 1'b1;
    endcase
    alu_zero = (alu_res == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and entry-movement decode; flush drops everything including a same-cycle accept.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          next_state   = S_ONE;
          load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && !out_ready) begin
          next_state = S_FULL;
          load_skid  = 1'b1;
        end else if (accept && out_ready) begin
          load_main_in = 1'b1;
        end else if (out_ready) begin
          next_state = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_ready) begin
          next_state     = S_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: next_state = S_EMPTY;
    endcase
    if (flush) begin
      next_state     = S_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Entry storage: main feeds the outputs, skid catches the entry that arrives while main is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_res  <= '0;
      main_zero <= 1'b0;
      main_ovf  <= 1'b0;
      main_ill  <= 1'b0;
      skid_res  <= '0;
      skid_zero <= 1'b0;
      skid_ovf  <= 1'b0;
      skid_ill  <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_res  <= alu_res;
        main_zero <= alu_zero;
        main_ovf  <= alu_ovf;
        main_ill  <= alu_ill;
      end else if (load_main_skid) begin
        main_res  <= skid_res;
        main_zero <= skid_zero;
        main_ovf  <= skid_ovf;
        main_ill  <= skid_ill;
      end
      if (load_skid) begin
        skid_res  <= alu_res;
        skid_zero <= alu_zero;
        skid_ovf  <= alu_ovf;
        skid_ill  <= alu_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Purpose: self-checking bench for alu_exec_stage with a result scoreboard.
// Latency: expectations pushed on accept, compared while out_valid is high.
// Backpressure: out_ready forced or randomised; entries must emerge in acceptance order.
module tb_alu_exec_stage;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             o;
    logic             i;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal_op;

  logic             rdy_force;
  logic             rnd_on;
  logic             rnd_rdy;

  exp_t exp_cur;
  exp_t sb_q[$];

  int n_checks;
  int n_fails;

  alu_exec_stage #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_ctrl   (alu_ctrl),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_ready = rnd_on ? rnd_rdy : rdy_force;

  // Random downstream stalls when enabled.
  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH:0] w;
    e.res = '0;
    e.o   = 1'b0;
    e.i   = 1'b0;
    w     = '0;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        w     = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        e.res = w[WIDTH-1:0];
        e.o   = w[WIDTH] ^ w[WIDTH-1];
      end
      4'b0110: begin
        w     = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        e.res = w[WIDTH-1:0];
        e.o   = w[WIDTH] ^ w[WIDTH-1];
      end
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1100: e.res = ~(a | b);
      default: e.i = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Scoreboard: compare the head while an entry is shown, retire on handshake, record accepts.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          chk("result",     {32'd0, result},         {32'd0, sb_q[0].res});
          chk("zero",       {63'd0, zero},           {63'd0, sb_q[0].z});
          chk("overflow",   {63'd0, overflow},       {63'd0, sb_q[0].o});
          chk("illegal_op", {63'd0, illegal_op},     {63'd0, sb_q[0].i});
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      if (in_valid && in_ready) sb_q.push_back(exp_cur);
    end
  end

  task automatic drive(input logic [3:0] c, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input exp_t e);
    logic acc;
    int   n;
    in_valid  = 1'b1;
    alu_ctrl  = c;
    operand_a = a;
    operand_b = b;
    exp_cur   = e;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] er, input logic ez, input logic eo, input logic ei);
    exp_t e;
    e.res = er;
    e.z   = ez;
    e.o   = eo;
    e.i   = ei;
    drive(c, a, b, e);
  endtask

  task automatic send_rand(input logic [3:0] c, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    drive(c, a, b, model(c, a, b));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes [8];
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0010;
    operand_a = 32'd3;
    operand_b = 32'd4;
    exp_cur   = model(4'b0010, 32'd3, 32'd4);
    rdy_force = 1'b1;
    rnd_on    = 1'b0;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};

    // Reset with a valid op presented: nothing may be captured.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",  {63'd0, out_valid},  64'd0);
    chk("rst_in_ready",   {63'd0, in_ready},   64'd1);
    chk("rst_result",     {32'd0, result},     64'd0);
    chk("rst_zero",       {63'd0, zero},       64'd0);
    chk("rst_overflow",   {63'd0, overflow},   64'd0);
    chk("rst_illegal_op", {63'd0, illegal_op}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back with downstream always ready.
    send(4'b0010, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0, 1'b0);
    send(4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send(4'b0000, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1'b0);
    send(4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    // Overflow, signed compare, zero result, illegal code.
    send(4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
    send(4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    send(4'b0011, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: A and B fill the stage, C waits upstream until release.
    rdy_force = 1'b0;
    send(4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_in_ready",  {63'd0, in_ready},  64'd0);
    chk("full_out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    fork
      send(4'b0110, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 rdy_force = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", sb_q.size(), 64'd0);

    // Flush while full with a new op offered: all of it disappears.
    rdy_force = 1'b0;
    send(4'b0010, 32'd100, 32'd1, 32'd101, 1'b0, 1'b0, 1'b0);
    send(4'b0010, 32'd200, 32'd2, 32'd202, 1'b0, 1'b0, 1'b0);
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0001;
    operand_a = 32'h55;
    operand_b = 32'hAA;
    exp_cur   = model(4'b0001, 32'h55, 32'hAA);
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready",  {63'd0, in_ready},  64'd1);
    rdy_force = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Random traffic with random downstream stalls.
    rnd_on = 1'b1;
    for (int k = 0; k < 300; k++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 3) == 0) rb = ra;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      send_rand(codes[$urandom_range(0, 7)], ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_on = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("final_drained", sb_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
